// File: rtl/program_loader.sv
// Loads a byte-stream program image into instruction memory word by word and
// keeps the core in reset until the complete image has been written.
module program_loader #(
    parameter int data_bits           = 32,
    parameter int memory_size         = 1024,
    parameter int memory_address_bits = $clog2(memory_size),
    parameter int timeout_cycles      = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_data,
    output logic                           byte_ready,
    output logic                           mem_write_enable,
    output logic [memory_address_bits-1:0] mem_address,
    output logic [data_bits-1:0]           mem_data,
    output logic                           core_reset,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [15:0]                    words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                         state_q, state_d;
    logic                           header_hi_q, header_hi_d;
    logic [1:0]                     byte_cnt_q, byte_cnt_d;
    logic [15:0]                    word_count_q, word_count_d;
    logic [data_bits-1:0]           assembly_q, assembly_d;
    logic [15:0]                    words_loaded_q, words_loaded_d;
    logic [memory_address_bits-1:0] address_q, address_d;
    logic [31:0]                    timeout_q, timeout_d;

    logic        transfer;
    logic        timeout_hit;
    logic [15:0] header_word;
    logic [15:0] words_next;

    assign transfer    = byte_valid && byte_ready;
    assign header_word = {byte_data, word_count_q[7:0]};
    assign words_next  = words_loaded_q + 16'd1;
    assign timeout_hit = (timeout_cycles != 0) && (timeout_q == 32'(timeout_cycles - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            header_hi_q    <= 1'b0;
            byte_cnt_q     <= '0;
            word_count_q   <= '0;
            assembly_q     <= '0;
            words_loaded_q <= '0;
            address_q      <= '0;
            timeout_q      <= '0;
        end else begin
            state_q        <= state_d;
            header_hi_q    <= header_hi_d;
            byte_cnt_q     <= byte_cnt_d;
            word_count_q   <= word_count_d;
            assembly_q     <= assembly_d;
            words_loaded_q <= words_loaded_d;
            address_q      <= address_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        header_hi_d    = header_hi_q;
        byte_cnt_d     = byte_cnt_q;
        word_count_d   = word_count_q;
        assembly_d     = assembly_q;
        words_loaded_d = words_loaded_q;
        address_d      = address_q;
        timeout_d      = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d        = ST_HEADER;
                    header_hi_d    = 1'b0;
                    byte_cnt_d     = '0;
                    word_count_d   = '0;
                    words_loaded_d = '0;
                    timeout_d      = '0;
                end
            end
            ST_HEADER: begin
                if (transfer) begin
                    timeout_d = '0;
                    if (!header_hi_q) begin
                        word_count_d = {8'h00, byte_data};
                        header_hi_d  = 1'b1;
                    end else begin
                        word_count_d = header_word;
                        if (header_word == 16'd0)
                            state_d = ST_DONE;
                        else if (32'(header_word) > 32'(memory_size / 4))
                            state_d = ST_ERROR;
                        else
                            state_d = ST_DATA;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end else if (timeout_cycles != 0) begin
                    timeout_d = timeout_q + 32'd1;
                end
            end
            ST_DATA: begin
                // First byte of a word ends up in the low byte after four shifts.
                if (transfer) begin
                    timeout_d  = '0;
                    assembly_d = {byte_data, assembly_q[data_bits-1:8]};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        address_d  = memory_address_bits'({words_loaded_q, 2'b00});
                        state_d    = ST_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end else if (timeout_cycles != 0) begin
                    timeout_d = timeout_q + 32'd1;
                end
            end
            ST_WRITE: begin
                words_loaded_d = words_next;
                state_d        = (words_next == word_count_q) ? ST_DONE : ST_DATA;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign byte_ready       = (state_q == ST_HEADER) || (state_q == ST_DATA);
    assign mem_write_enable = (state_q == ST_WRITE);
    assign mem_address      = address_q;
    assign mem_data         = assembly_q;
    assign core_reset       = (state_q != ST_DONE);
    assign busy             = (state_q == ST_HEADER) || (state_q == ST_DATA) || (state_q == ST_WRITE);
    assign done             = (state_q == ST_DONE);
    assign error            = (state_q == ST_ERROR);
    assign words_loaded     = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads with random payloads
// checked against a stream-parsing reference model, plus hand-written corner cases.
module tb_program_loader;

    localparam int MEM_SIZE  = 1024;
    localparam int ADDR_BITS = $clog2(MEM_SIZE);
    localparam int TIMEOUT   = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 byte_valid = 1'b0;
    logic [7:0]           byte_data = 8'h00;
    logic                 byte_ready;
    logic                 mem_write_enable;
    logic [ADDR_BITS-1:0] mem_address;
    logic [31:0]          mem_data;
    logic                 core_reset;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [15:0]          words_loaded;

    program_loader #(
        .data_bits(32),
        .memory_size(MEM_SIZE),
        .memory_address_bits(ADDR_BITS),
        .timeout_cycles(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .mem_write_enable(mem_write_enable),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .core_reset(core_reset),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    logic [ADDR_BITS-1:0] seenAddr[$];
    logic [31:0]          seenData[$];
    int                   readyDuringWrite = 0;

    logic [7:0]           streamQ[$];
    logic [ADDR_BITS-1:0] expAddr[$];
    logic [31:0]          expData[$];

    typedef struct {
        int n;
        bit stall;
        int startAt;
        bit expDone;
        bit expError;
        int expWords;
    } loadCase_t;

    loadCase_t caseTable[8];
    logic [7:0] basicBytes[10];

    // Record every write strobe seen by the memory, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_write_enable) begin
            seenAddr.push_back(mem_address);
            seenData.push_back(mem_data);
            if (byte_ready)
                readyDuringWrite++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearSeen();
        seenAddr.delete();
        seenData.delete();
        readyDuringWrite = 0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Holds a byte on the bus until an edge where the loader was ready takes it.
    task automatic sendByte(input logic [7:0] b);
        logic rdy;
        int guard;
        byte_valid = 1'b1;
        byte_data  = b;
        guard      = 0;
        rdy        = 1'b0;
        while (!rdy && guard < 50) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!rdy)
            checkOutput("byteAccepted", 32'd0, 32'd1);
    endtask

    task automatic buildStream(input int n);
        streamQ.delete();
        streamQ.push_back(n[7:0]);
        streamQ.push_back(n[15:8]);
        if (n >= 1 && n <= MEM_SIZE / 4) begin
            for (int i = 0; i < 4 * n; i++)
                streamQ.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // Reference model: parse the byte stream into the list of expected writes.
    task automatic modelStream();
        int count;
        expAddr.delete();
        expData.delete();
        count = int'(streamQ[0]) + 256 * int'(streamQ[1]);
        if (count > 0 && count <= MEM_SIZE / 4) begin
            for (int i = 0; i < count; i++) begin
                expAddr.push_back(ADDR_BITS'(4 * i));
                expData.push_back({streamQ[2 + 4 * i + 3], streamQ[2 + 4 * i + 2],
                                   streamQ[2 + 4 * i + 1], streamQ[2 + 4 * i]});
            end
        end
    endtask

    task automatic compareLoad(input string name, input bit expDone, input bit expError, input int expWords);
        checkOutput({name, ".done"}, 32'(done), 32'(expDone));
        checkOutput({name, ".error"}, 32'(error), 32'(expError));
        checkOutput({name, ".coreReset"}, 32'(core_reset), 32'(!expDone));
        checkOutput({name, ".busy"}, 32'(busy), 32'd0);
        checkOutput({name, ".wordsLoaded"}, 32'(words_loaded), 32'(expWords));
        checkOutput({name, ".writeCount"}, 32'(seenAddr.size()), 32'(expAddr.size()));
        for (int i = 0; i < expAddr.size() && i < seenAddr.size(); i++) begin
            checkOutput($sformatf("%s.addr%0d", name, i), 32'(seenAddr[i]), 32'(expAddr[i]));
            checkOutput($sformatf("%s.data%0d", name, i), seenData[i], expData[i]);
        end
        checkOutput({name, ".readyInWrite"}, 32'(readyDuringWrite), 32'd0);
    endtask

    task automatic applyStimulus(input string name, input bit stall, input int startAt,
                                 input bit expDone, input bit expError, input int expWords);
        clearSeen();
        modelStream();
        pulseStart();
        for (int i = 0; i < streamQ.size(); i++) begin
            sendByte(streamQ[i]);
            if (stall && i != streamQ.size() - 1) begin
                byte_valid = 1'b0;
                if (i == startAt)
                    start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        byte_valid = 1'b0;
        for (int i = 0; i < 20 && !(done || error); i++) begin
            @(posedge clk);
            #1;
        end
        compareLoad(name, expDone, expError, expWords);
    endtask

    initial begin
        caseTable[0] = '{n: 2,     stall: 1'b0, startAt: -1, expDone: 1'b1, expError: 1'b0, expWords: 2};
        caseTable[1] = '{n: 3,     stall: 1'b1, startAt: 4,  expDone: 1'b1, expError: 1'b0, expWords: 3};
        caseTable[2] = '{n: 0,     stall: 1'b0, startAt: -1, expDone: 1'b1, expError: 1'b0, expWords: 0};
        caseTable[3] = '{n: 257,   stall: 1'b0, startAt: -1, expDone: 1'b0, expError: 1'b1, expWords: 0};
        caseTable[4] = '{n: 5,     stall: 1'b0, startAt: -1, expDone: 1'b1, expError: 1'b0, expWords: 5};
        caseTable[5] = '{n: 256,   stall: 1'b0, startAt: -1, expDone: 1'b1, expError: 1'b0, expWords: 256};
        caseTable[6] = '{n: 65535, stall: 1'b0, startAt: -1, expDone: 1'b0, expError: 1'b1, expWords: 0};
        caseTable[7] = '{n: 1,     stall: 1'b1, startAt: 1,  expDone: 1'b1, expError: 1'b0, expWords: 1};
        basicBytes = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};

        // Reset values while reset is held.
        @(posedge clk);
        #1;
        checkOutput("reset.byteReady", 32'(byte_ready), 32'd0);
        checkOutput("reset.we", 32'(mem_write_enable), 32'd0);
        checkOutput("reset.addr", 32'(mem_address), 32'd0);
        checkOutput("reset.data", mem_data, 32'd0);
        checkOutput("reset.coreReset", 32'(core_reset), 32'd1);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.error", 32'(error), 32'd0);
        checkOutput("reset.wordsLoaded", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle.byteReady", 32'(byte_ready), 32'd0);

        // Basic load with exact write timing.
        clearSeen();
        pulseStart();
        checkOutput("basic.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++)
            sendByte(basicBytes[i]);
        checkOutput("basic.we0", 32'(mem_write_enable), 32'd1);
        checkOutput("basic.ready0", 32'(byte_ready), 32'd0);
        checkOutput("basic.addr0", 32'(mem_address), 32'd0);
        checkOutput("basic.data0", mem_data, 32'h00500513);
        for (int i = 6; i < 10; i++)
            sendByte(basicBytes[i]);
        checkOutput("basic.we1", 32'(mem_write_enable), 32'd1);
        checkOutput("basic.ready1", 32'(byte_ready), 32'd0);
        checkOutput("basic.addr1", 32'(mem_address), 32'd4);
        checkOutput("basic.data1", mem_data, 32'h00A00593);
        checkOutput("basic.coreResetInWrite", 32'(core_reset), 32'd1);
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("basic.done", 32'(done), 32'd1);
        checkOutput("basic.coreReset", 32'(core_reset), 32'd0);
        checkOutput("basic.wordsLoaded", 32'(words_loaded), 32'd2);
        checkOutput("basic.writeCount", 32'(seenAddr.size()), 32'd2);
        checkOutput("basic.addrHold", 32'(mem_address), 32'd4);

        // Empty image: DONE two edges after the start edge.
        clearSeen();
        pulseStart();
        sendByte(8'h00);
        checkOutput("empty.notYetDone", 32'(done), 32'd0);
        sendByte(8'h00);
        byte_valid = 1'b0;
        checkOutput("empty.done", 32'(done), 32'd1);
        checkOutput("empty.writeCount", 32'(seenAddr.size()), 32'd0);
        checkOutput("empty.wordsLoaded", 32'(words_loaded), 32'd0);

        // Table-driven loads with random payloads.
        foreach (caseTable[i]) begin
            buildStream(caseTable[i].n);
            applyStimulus($sformatf("case%0d", i), caseTable[i].stall, caseTable[i].startAt,
                          caseTable[i].expDone, caseTable[i].expError, caseTable[i].expWords);
        end

        // Random word counts and stall patterns.
        for (int r = 0; r < 4; r++) begin
            int n;
            bit stall;
            n     = $urandom_range(1, 12);
            stall = 1'($urandom_range(0, 1));
            buildStream(n);
            applyStimulus($sformatf("rand%0d", r), stall, stall ? 2 : -1, 1'b1, 1'b0, n);
        end

        // Timeout: three payload bytes then silence.
        clearSeen();
        pulseStart();
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        byte_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk);
            #1;
            if (k == TIMEOUT - 1)
                checkOutput("timeout.early", 32'(error), 32'd0);
            if (k == TIMEOUT)
                checkOutput("timeout.error", 32'(error), 32'd1);
        end
        checkOutput("timeout.coreReset", 32'(core_reset), 32'd1);
        checkOutput("timeout.writeCount", 32'(seenAddr.size()), 32'd0);

        // Asynchronous reset after the first word of a two-word load.
        buildStream(2);
        clearSeen();
        pulseStart();
        for (int i = 0; i < 6; i++)
            sendByte(streamQ[i]);
        checkOutput("midReset.we", 32'(mem_write_enable), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midReset.byteReady", 32'(byte_ready), 32'd0);
        checkOutput("midReset.we0", 32'(mem_write_enable), 32'd0);
        checkOutput("midReset.addr", 32'(mem_address), 32'd0);
        checkOutput("midReset.data", mem_data, 32'd0);
        checkOutput("midReset.coreReset", 32'(core_reset), 32'd1);
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.done", 32'(done), 32'd0);
        checkOutput("midReset.error", 32'(error), 32'd0);
        checkOutput("midReset.wordsLoaded", 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("reload", 1'b0, -1, 1'b1, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
